memcore_uram_pipe: RTL
======================

# memcore_uram_pipe

Parametrised true dual-port URAM memory core. It is the successor to the single-cycle dual-port memcore and adds:
- per-byte write enables
- a configurable read pipeline of 1–4 cycles with per-port read-valid strobes
- a selectable read-during-write mode
- deterministic same-address write collision resolution with a collision flag

It sits under the generated buffer/channel wrappers wherever a deep, wide on-chip store needs extra read pipelining for timing closure.

## Interface
- DATA_WIDTH, 64, word width in bits; must be a multiple of BYTE_WIDTH
- BYTE_WIDTH, 8, bits per write-enable lane; NB = DATA_WIDTH/BYTE_WIDTH
- ADDRESS_WIDTH, 12, address bus width
- ADDRESS_RANGE, 4096, number of words; must be ≤ 2^ADDRESS_WIDTH
- READ_LATENCY, 3, cycles from read issue to q; legal range 1..4
- WRITE_MODE, 0, 0 = NO_CHANGE, 1 = READ_FIRST, 2 = WRITE_FIRST

Ports:
- clk  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-low; clears all pipeline/output state
- address0  in  ADDRESS_WIDTH  port 0 word address
- ce0  in  1  port 0 access enable
- d0  in  DATA_WIDTH  port 0 write data
- we0  in  NB  port 0 byte write enables; any bit set makes the access a write
- q0  out  DATA_WIDTH  port 0 read data
- qvalid0  out  1  port 0 read-data strobe
- address1, ce1, d1, we1, q1, qvalid1  same as above, for port 1
- collision  out  1  one-cycle pulse: both ports wrote an overlapping byte of the same word

## Operation
- Storage is a single array with ram_style "hls_ultra" and cascade_height 16. Contents are not reset.
- **Access class per port per cycle:**
  - idle: ce = 0
  - read: ce = 1, we = 0
  - write: ce = 1, we ≠ 0
- **Write:** bytes i with we[i] = 1 are replaced by the matching byte of d; other bytes are unchanged.
- **Read issue:**
  - A read always issues a read.
  - A write issues a read only when WRITE_MODE ≠ NO_CHANGE.
  - READ_FIRST returns the pre-write word.
  - WRITE_FIRST returns the word after this port's own byte merge.
- **Cross-port same-cycle access to the same address:**
  - A read returns the pre-write word for the other port's bytes, in every mode.
  - Dual write: per byte, port 0 wins where both enable; port 1 bytes apply where only port 1 enables.
  - collision asserts in the next cycle iff the address is equal and (we0 & we1) ≠ 0.
- **Out-of-range address (≥ ADDRESS_RANGE):** the write is dropped. A read still issues and returns all zeros, and qvalid still pulses.
- **Read pipeline:** per port, READ_LATENCY stages of {data, valid}.
  - Stage 1 is the array read register; each later stage is a plain register.
  - q loads only when the final-stage valid = 1. Otherwise q holds its last value.
  - qvalid equals the final-stage valid.

## Timing
- Reset (reset = 0, asynchronous):
  - q0, q1 are 0; qvalid0, qvalid1, collision are 0.
  - All pipeline valid bits are 0.
  - Array contents are preserved.
- Reset mid-operation flushes in-flight reads: no qvalid appears for reads issued before reset assertion.
- Accesses are sampled from the first rising edge after reset deasserts.
- A read issued at edge T gives q and qvalid = 1 from edge T + READ_LATENCY, lasting 1 cycle. qvalid is high for exactly one cycle per issued read.
- Throughput is one access per port per cycle. Back-to-back reads give consecutive qvalid pulses in issue order.
- A write at edge T is visible to a read on either port issued at edge T+1 or later.
- collision is registered and pulses at T+1 for a colliding write at T. It is independent of READ_LATENCY.
- There is no backpressure; the consumer must accept q when qvalid = 1.

## Test plan
- **Reset values:** assert reset mid-stream with 3 reads in flight (READ_LATENCY = 3) → q0 = q1 = 0, no qvalid for those reads, and a word written pre-reset reads back intact after reset.
- **Latency/throughput:** write 0x1111…, 0x2222…, 0x3333… to addresses 0, 1, 2; read addresses 0, 1, 2 back-to-back on port 1 at T, T+1, T+2 → qvalid1 high at T+3..T+5 with the data in order. Repeat for READ_LATENCY = 1 and 4.
- **Byte enables:** address 5 holds 0xAAAA_AAAA_AAAA_AAAA; write d = 0x1122334455667788 with we0 = 8'b0000_0101 → readback 0xAAAA_AAAA_AA66_AA88.
- **WRITE_MODE:** address 7 holds 0x0F; write 0xF0 with all we bits set.
  - NO_CHANGE → qvalid stays 0 and q holds.
  - READ_FIRST → q = 0x0F.
  - WRITE_FIRST → q = 0xF0.
- **Dual-write collision:** both ports write address 9 in one cycle, we0 = 8'h0F, we1 = 8'hFF, d0 = all 0x11, d1 = all 0x22 → word = 0x2222_2222_1111_1111 and collision = 1 for exactly one cycle. With disjoint we, collision stays 0.
- **Boundaries:** ADDRESS_RANGE = 4000; a write to 4000 is dropped (address 4000 − 4096 alias unaffected); a read of 4000 → q = 0 with qvalid pulse; address 3999 read/write work normally; a cross-port read of an address being written → old word.

Source files
------------

// File: rtl/memcore_uram_pipe.sv
// memcore_uram_pipe
//   True dual-port URAM word store with per-byte write enables, a read
//   pipeline of READ_LATENCY (1..4) stages per port, a selectable
//   read-during-write mode and a registered same-word dual-write collision flag.
//
// Ports
//   clk                     sole clock, rising edge
//   reset                   asynchronous active-low; clears pipeline and outputs
//   address0/1              word address per port
//   ce0/1                   access enable per port
//   d0/1                    write data per port
//   we0/1                   byte write enables; any bit set makes the access a write
//   q0/1                    read data, held between read-valid strobes
//   qvalid0/1               one-cycle strobe per issued read
//   collision               one-cycle pulse after both ports wrote an overlapping byte
//
// WRITE_MODE: 0 = NO_CHANGE, 1 = READ_FIRST, 2 = WRITE_FIRST
module memcore_uram_pipe #(
    parameter int DATA_WIDTH    = 64,
    parameter int BYTE_WIDTH    = 8,
    parameter int ADDRESS_WIDTH = 12,
    parameter int ADDRESS_RANGE = 4096,
    parameter int READ_LATENCY  = 3,
    parameter int WRITE_MODE    = 0
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [ADDRESS_WIDTH-1:0]            address0,
    input  logic                                ce0,
    input  logic [DATA_WIDTH-1:0]               d0,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0]    we0,
    output logic [DATA_WIDTH-1:0]               q0,
    output logic                                qvalid0,
    input  logic [ADDRESS_WIDTH-1:0]            address1,
    input  logic                                ce1,
    input  logic [DATA_WIDTH-1:0]               d1,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0]    we1,
    output logic [DATA_WIDTH-1:0]               q1,
    output logic                                qvalid1,
    output logic                                collision
);

    localparam int NB          = DATA_WIDTH / BYTE_WIDTH;
    localparam int NO_CHANGE   = 0;
    localparam int WRITE_FIRST = 2;
    localparam logic [ADDRESS_WIDTH:0] ADDR_LIMIT = (ADDRESS_WIDTH+1)'(ADDRESS_RANGE);

    (* ram_style = "hls_ultra", cascade_height = 16 *)
    logic [DATA_WIDTH-1:0] mem [0:ADDRESS_RANGE-1];

    logic [ADDRESS_WIDTH-1:0] addr      [2];
    logic                     ce        [2];
    logic [DATA_WIDTH-1:0]    din       [2];
    logic [NB-1:0]            wen       [2];

    logic                     in_range  [2];
    logic                     is_write  [2];
    logic                     wr_commit [2];
    logic                     rd_issue  [2];
    logic [ADDRESS_WIDTH-1:0] rd_idx    [2];
    logic [DATA_WIDTH-1:0]    rd_word   [2];

    logic [DATA_WIDTH-1:0]    pipe_data  [2][READ_LATENCY];
    logic                     pipe_valid [2][READ_LATENCY];

    always_comb begin
        addr[0] = address0;  addr[1] = address1;
        ce[0]   = ce0;       ce[1]   = ce1;
        din[0]  = d0;        din[1]  = d1;
        wen[0]  = we0;       wen[1]  = we1;
    end

    // Read word per port. The array read sees the pre-write contents, so the
    // other port's same-cycle write never leaks into this port's result; only
    // WRITE_FIRST folds in this port's own bytes.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            in_range[p]  = ({1'b0, addr[p]} < ADDR_LIMIT);
            is_write[p]  = ce[p] && (wen[p] != '0);
            wr_commit[p] = is_write[p] && in_range[p];
            rd_issue[p]  = ce[p] && (!is_write[p] || (WRITE_MODE != NO_CHANGE));
            rd_idx[p]    = in_range[p] ? addr[p] : '0;
            rd_word[p]   = mem[rd_idx[p]];
            if ((WRITE_MODE == WRITE_FIRST) && is_write[p]) begin
                for (int b = 0; b < NB; b++) begin
                    if (wen[p][b]) begin
                        rd_word[p][b*BYTE_WIDTH +: BYTE_WIDTH] = din[p][b*BYTE_WIDTH +: BYTE_WIDTH];
                    end
                end
            end
            if (!in_range[p]) begin
                rd_word[p] = '0;
            end
        end
    end

    // Port 1 is applied first so that port 0 overrides it on shared bytes.
    always_ff @(posedge clk) begin
        for (int p = 1; p >= 0; p--) begin
            if (wr_commit[p]) begin
                for (int b = 0; b < NB; b++) begin
                    if (wen[p][b]) begin
                        mem[addr[p]][b*BYTE_WIDTH +: BYTE_WIDTH] <= din[p][b*BYTE_WIDTH +: BYTE_WIDTH];
                    end
                end
            end
        end
    end

    // Data registers load only behind a valid, so the last stage doubles as
    // the q hold register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int p = 0; p < 2; p++) begin
                for (int s = 0; s < READ_LATENCY; s++) begin
                    pipe_data[p][s]  <= '0;
                    pipe_valid[p][s] <= 1'b0;
                end
            end
            collision <= 1'b0;
        end else begin
            for (int p = 0; p < 2; p++) begin
                pipe_valid[p][0] <= rd_issue[p];
                if (rd_issue[p]) begin
                    pipe_data[p][0] <= rd_word[p];
                end
                for (int s = 1; s < READ_LATENCY; s++) begin
                    pipe_valid[p][s] <= pipe_valid[p][s-1];
                    if (pipe_valid[p][s-1]) begin
                        pipe_data[p][s] <= pipe_data[p][s-1];
                    end
                end
            end
            collision <= is_write[0] && is_write[1] && (addr[0] == addr[1])
                         && ((wen[0] & wen[1]) != '0);
        end
    end

    assign q0      = pipe_data[0][READ_LATENCY-1];
    assign qvalid0 = pipe_valid[0][READ_LATENCY-1];
    assign q1      = pipe_data[1][READ_LATENCY-1];
    assign qvalid1 = pipe_valid[1][READ_LATENCY-1];

endmodule
